// File: rtl/counter_pkg.sv
// Shared mode constants and the per-edge operation type for the up/down counter.
package counter_pkg;

  localparam int MODE_WRAP  = 0;
  localparam int MODE_SAT   = 1;
  localparam int EDGE_PULSE = 1;
  localparam int EDGE_LEVEL = 0;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_LOAD,
    OP_UP,
    OP_DN
  } op_e;

endpackage

// File: rtl/req_sync.sv
// Two-stage request synchroniser with rising-edge or level step output.
module req_sync
  import counter_pkg::*;
#(
  parameter int EDGE_MODE = EDGE_PULSE
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  output logic step
);

  logic s1;
  logic s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= req;
      s2 <= s1;
    end
  end

  // Clearing s2 on reset makes a request held across reset release count once.
  assign step = (EDGE_MODE == EDGE_LEVEL) ? s1 : (s1 & ~s2);

endmodule

// File: rtl/updown_counter.sv
// Up/down counter with synchronised requests, load, wrap or saturate at 0/MAX.
module updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH     = 4,
  parameter longint unsigned MAX       = (64'd1 << WIDTH) - 64'd1,
  parameter int              SATURATE  = MODE_WRAP,
  parameter int              EDGE_MODE = EDGE_PULSE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             at_zero,
  output logic             at_max,
  output logic             wrap
);

  generate
    if (WIDTH < 1 || WIDTH > 32 || MAX < 64'd1 || MAX >= (64'd1 << WIDTH) ||
        (SATURATE != MODE_WRAP && SATURATE != MODE_SAT) ||
        (EDGE_MODE != EDGE_PULSE && EDGE_MODE != EDGE_LEVEL)) begin : g_bad_params
      $error("updown_counter: illegal parameter combination");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_C = MAX[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic             step_up;
  logic             step_dn;
  op_e              op;
  logic [WIDTH-1:0] count_next;
  logic             wrap_next;

  req_sync #(.EDGE_MODE(EDGE_MODE)) u_inc_sync (
    .clk   (clk),
    .reset (reset),
    .req   (inc),
    .step  (step_up)
  );

  req_sync #(.EDGE_MODE(EDGE_MODE)) u_dec_sync (
    .clk   (clk),
    .reset (reset),
    .req   (dec),
    .step  (step_dn)
  );

  // Opposing steps in the same cycle cancel rather than racing.
  always_comb begin
    op = OP_HOLD;
    if (load)                     op = OP_LOAD;
    else if (step_up && !step_dn) op = OP_UP;
    else if (step_dn && !step_up) op = OP_DN;
  end

  always_comb begin
    count_next = count;
    wrap_next  = 1'b0;
    case (op)
      OP_LOAD: count_next = (load_value > MAX_C) ? MAX_C : load_value;
      OP_UP: begin
        if (count < MAX_C) begin
          count_next = count + ONE;
        end else if (SATURATE == MODE_WRAP) begin
          count_next = '0;
          wrap_next  = 1'b1;
        end
      end
      OP_DN: begin
        if (count != '0) begin
          count_next = count - ONE;
        end else if (SATURATE == MODE_WRAP) begin
          count_next = MAX_C;
          wrap_next  = 1'b1;
        end
      end
      OP_HOLD: count_next = count;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= count_next;
      wrap  <= wrap_next;
    end
  end

  assign at_zero = (count == '0);
  assign at_max  = (count == MAX_C);

endmodule

// File: tb/tb_updown_counter.sv
// Self-checking bench for updown_counter across wrap, saturate and level/edge variants.
module tb_updown_counter;

  typedef struct {
    logic       i;
    logic       d;
    logic       ld;
    logic [3:0] lv;
    logic       r;
    logic [3:0] c;
    logic       w;
  } step_t;

  typedef struct {
    int         dut;
    logic [3:0] c;
    logic       w;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       inc  [4];
  logic       dec  [4];
  logic       load [4];
  logic [3:0] lv   [4];
  logic [3:0] cnt  [4];
  logic       az   [4];
  logic       am   [4];
  logic       wr   [4];

  logic [3:0] maxv [4] = '{4'd15, 4'd9, 4'd15, 4'd15};

  exp_t q[$];
  int   tests  = 0;
  int   failed = 0;

  // 0: defaults, 1: MAX=9 wrap, 2: saturate, 3: level mode
  updown_counter u_def (
    .clk(clk), .reset(reset), .inc(inc[0]), .dec(dec[0]), .load(load[0]),
    .load_value(lv[0]), .count(cnt[0]), .at_zero(az[0]), .at_max(am[0]), .wrap(wr[0])
  );

  updown_counter #(.WIDTH(4), .MAX(9), .SATURATE(0), .EDGE_MODE(1)) u_m9 (
    .clk(clk), .reset(reset), .inc(inc[1]), .dec(dec[1]), .load(load[1]),
    .load_value(lv[1]), .count(cnt[1]), .at_zero(az[1]), .at_max(am[1]), .wrap(wr[1])
  );

  updown_counter #(.WIDTH(4), .MAX(15), .SATURATE(1), .EDGE_MODE(1)) u_sat (
    .clk(clk), .reset(reset), .inc(inc[2]), .dec(dec[2]), .load(load[2]),
    .load_value(lv[2]), .count(cnt[2]), .at_zero(az[2]), .at_max(am[2]), .wrap(wr[2])
  );

  updown_counter #(.WIDTH(4), .MAX(15), .SATURATE(0), .EDGE_MODE(0)) u_lvl (
    .clk(clk), .reset(reset), .inc(inc[3]), .dec(dec[3]), .load(load[3]),
    .load_value(lv[3]), .count(cnt[3]), .at_zero(az[3]), .at_max(am[3]), .wrap(wr[3])
  );

  function automatic step_t mk(input logic i, input logic d, input logic ld,
                               input logic [3:0] lval, input logic r,
                               input logic [3:0] c, input logic w);
    step_t s;
    s.i = i; s.d = d; s.ld = ld; s.lv = lval; s.r = r; s.c = c; s.w = w;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle of stimulus and queues the state expected after the next edge.
  task automatic drive(input int dut, input step_t s);
    exp_t e;
    inc[dut]  = s.i;
    dec[dut]  = s.d;
    load[dut] = s.ld;
    lv[dut]   = s.lv;
    reset     = s.r;
    e.dut = dut;
    e.c   = s.c;
    e.w   = s.w;
    q.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    for (int d = 0; d < 4; d++) begin
      drive(d, mk(0, 0, 0, 4'd0, 1, 4'd0, 0));
      tick();
      e = q.pop_front();
      tests++;
      if (cnt[e.dut] !== e.c || wr[e.dut] !== e.w || az[e.dut] !== 1'b1 || am[e.dut] !== 1'b0) begin
        failed++;
        $display("FAIL reset dut%0d: count=%0d wrap=%b az=%b am=%b, want count=%0d wrap=%b az=1 am=0",
                 e.dut, cnt[e.dut], wr[e.dut], az[e.dut], am[e.dut], e.c, e.w);
      end
    end
    reset = 1'b0;
  endtask

  task automatic run_table(input string name, input int dut, input step_t tbl[$]);
    exp_t e;
    for (int k = 0; k < tbl.size(); k++) begin
      drive(dut, tbl[k]);
      tick();
      e = q.pop_front();
      tests++;
      if (cnt[e.dut] !== e.c || wr[e.dut] !== e.w ||
          az[e.dut] !== (e.c == 4'd0) || am[e.dut] !== (e.c == maxv[e.dut])) begin
        failed++;
        $display("FAIL %s[%0d] dut%0d: count=%0d wrap=%b az=%b am=%b, want count=%0d wrap=%b",
                 name, k, e.dut, cnt[e.dut], wr[e.dut], az[e.dut], am[e.dut], e.c, e.w);
      end
    end
  endtask

  task automatic test_latency();
    step_t t[$];
    t.push_back(mk(1, 0, 0, 4'd0, 0, 4'd0, 0));
    t.push_back(mk(0, 0, 0, 4'd0, 0, 4'd1, 0));
    t.push_back(mk(0, 0, 0, 4'd0, 0, 4'd1, 0));
    run_table("latency", 0, t);
  endtask

  task automatic test_mod_wrap();
    step_t t[$];
    t.push_back(mk(0, 0, 1, 4'd9, 0, 4'd9, 0));
    t.push_back(mk(1, 0, 0, 4'd0, 0, 4'd9, 0));
    t.push_back(mk(0, 0, 0, 4'd0, 0, 4'd0, 1));
    t.push_back(mk(0, 0, 0, 4'd0, 0, 4'd0, 0));
    t.push_back(mk(0, 1, 0, 4'd0, 0, 4'd0, 0));
    t.push_back(mk(0, 0, 0, 4'd0, 0, 4'd9, 1));
    t.push_back(mk(0, 0, 0, 4'd0, 0, 4'd9, 0));
    run_table("mod_wrap", 1, t);
  endtask

  task automatic test_saturate();
    step_t t[$];
    t.push_back(mk(0, 0, 1, 4'd15, 0, 4'd15, 0));
    for (int n = 0; n < 3; n++) begin
      t.push_back(mk(1, 0, 0, 4'd0, 0, 4'd15, 0));
      t.push_back(mk(0, 0, 0, 4'd0, 0, 4'd15, 0));
    end
    t.push_back(mk(0, 0, 1, 4'd0, 0, 4'd0, 0));
    t.push_back(mk(0, 1, 0, 4'd0, 0, 4'd0, 0));
    t.push_back(mk(0, 0, 0, 4'd0, 0, 4'd0, 0));
    t.push_back(mk(0, 0, 0, 4'd0, 0, 4'd0, 0));
    run_table("saturate", 2, t);
  endtask

  task automatic test_level_vs_edge();
    step_t lvl[$];
    step_t edg[$];
    lvl.push_back(mk(0, 0, 1, 4'd2, 0, 4'd2, 0));
    lvl.push_back(mk(1, 0, 0, 4'd0, 0, 4'd2, 0));
    lvl.push_back(mk(1, 0, 0, 4'd0, 0, 4'd3, 0));
    lvl.push_back(mk(1, 0, 0, 4'd0, 0, 4'd4, 0));
    lvl.push_back(mk(1, 0, 0, 4'd0, 0, 4'd5, 0));
    lvl.push_back(mk(1, 0, 0, 4'd0, 0, 4'd6, 0));
    lvl.push_back(mk(0, 0, 0, 4'd0, 0, 4'd7, 0));
    lvl.push_back(mk(0, 0, 0, 4'd0, 0, 4'd7, 0));
    run_table("level", 3, lvl);
    edg.push_back(mk(0, 0, 1, 4'd2, 0, 4'd2, 0));
    edg.push_back(mk(1, 0, 0, 4'd0, 0, 4'd2, 0));
    edg.push_back(mk(1, 0, 0, 4'd0, 0, 4'd3, 0));
    edg.push_back(mk(1, 0, 0, 4'd0, 0, 4'd3, 0));
    edg.push_back(mk(1, 0, 0, 4'd0, 0, 4'd3, 0));
    edg.push_back(mk(1, 0, 0, 4'd0, 0, 4'd3, 0));
    edg.push_back(mk(0, 0, 0, 4'd0, 0, 4'd3, 0));
    edg.push_back(mk(0, 0, 0, 4'd0, 0, 4'd3, 0));
    run_table("edge_hold", 0, edg);
  endtask

  task automatic test_back_to_back();
    step_t t[$];
    t.push_back(mk(1, 0, 0, 4'd0, 0, 4'd3, 0));
    t.push_back(mk(0, 0, 0, 4'd0, 0, 4'd4, 0));
    t.push_back(mk(1, 0, 0, 4'd0, 0, 4'd4, 0));
    t.push_back(mk(0, 0, 0, 4'd0, 0, 4'd5, 0));
    t.push_back(mk(0, 1, 0, 4'd0, 0, 4'd5, 0));
    t.push_back(mk(0, 0, 0, 4'd0, 0, 4'd4, 0));
    t.push_back(mk(0, 1, 0, 4'd0, 0, 4'd4, 0));
    t.push_back(mk(0, 0, 0, 4'd0, 0, 4'd3, 0));
    run_table("back_to_back", 0, t);
  endtask

  task automatic test_load_priority();
    step_t t[$];
    t.push_back(mk(0, 0, 1, 4'd4, 0, 4'd4, 0));
    t.push_back(mk(1, 0, 0, 4'd0, 0, 4'd4, 0));
    t.push_back(mk(0, 0, 1, 4'd12, 0, 4'd9, 0));
    t.push_back(mk(0, 0, 0, 4'd0, 0, 4'd9, 0));
    t.push_back(mk(0, 0, 1, 4'd5, 0, 4'd5, 0));
    t.push_back(mk(1, 1, 0, 4'd0, 0, 4'd5, 0));
    t.push_back(mk(0, 0, 0, 4'd0, 0, 4'd5, 0));
    t.push_back(mk(0, 0, 0, 4'd0, 0, 4'd5, 0));
    run_table("load_priority", 1, t);
  endtask

  task automatic test_reset_mid_step();
    step_t t[$];
    t.push_back(mk(0, 0, 1, 4'd5, 0, 4'd5, 0));
    t.push_back(mk(1, 0, 0, 4'd0, 0, 4'd5, 0));
    t.push_back(mk(1, 0, 0, 4'd0, 1, 4'd0, 0));
    t.push_back(mk(1, 0, 0, 4'd0, 0, 4'd0, 0));
    t.push_back(mk(1, 0, 0, 4'd0, 0, 4'd1, 0));
    t.push_back(mk(1, 0, 0, 4'd0, 0, 4'd1, 0));
    t.push_back(mk(1, 0, 0, 4'd0, 0, 4'd1, 0));
    t.push_back(mk(0, 0, 0, 4'd0, 0, 4'd1, 0));
    run_table("reset_mid_step", 0, t);
  endtask

  initial begin
    reset = 1'b0;
    for (int d = 0; d < 4; d++) begin
      inc[d] = 1'b0; dec[d] = 1'b0; load[d] = 1'b0; lv[d] = 4'd0;
    end
    tick();
    test_reset();
    test_latency();
    test_mod_wrap();
    test_saturate();
    test_level_vs_edge();
    test_back_to_back();
    test_load_priority();
    test_reset_mid_step();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
